// File: rtl/mem_bank_pkg.sv
// Shared types and constants for the parametrised data memory bank.
// No logic; widths default to the legacy 16x16 memory.
// Control FSM opcodes live here so port steering stays in the CPU controller.
package mem_bank_pkg;

    parameter int DATA_W_DEF = 16;
    parameter int ADDR_W_DEF = 4;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_READ,
        OP_STORE,
        OP_CLEAR
    } cpu_op_t;

endpackage

// File: rtl/mem_clear_seq.sv
// Bulk-clear sequencer: sweeps every address once, one word per cycle.
// Latency: busy from the cycle after accept; clr_done DEPTH+1 cycles after accept.
// Backpressure: clr_req is ignored while a sweep runs; the sweep is never restarted.
module mem_clear_seq
    import mem_bank_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we,
    output logic              busy,
    output logic              clr_done
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            clr_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                // Counter wraps to zero naturally after the last address.
                cnt_nxt = cnt + ADDR_W'(1);
                if (cnt == {ADDR_W{1'b1}}) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign clr_we   = (state == CLEAR);
    assign busy     = (state == CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/mem_bank_param.sv
// Parametrised data memory: two registered read ports, one write port, bulk clear.
// Latency: read data and rd_valid/wr_done one cycle after accept; write-first forwarding.
// Backpressure: none in IDLE; all requests dropped silently while busy.
module mem_bank_param
    import mem_bank_pkg::*;
#(
    parameter int              DATA_W  = DATA_W_DEF,
    parameter int              ADDR_W  = ADDR_W_DEF,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_done,
    input  logic              clr_req,
    output logic              clr_done,
    output logic              busy
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_we;
    logic              rd_acc, wr_acc;

    mem_clear_seq #(.ADDR_W(ADDR_W)) u_clr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .clr_addr (clr_addr),
        .clr_we   (clr_we),
        .busy     (busy),
        .clr_done (clr_done)
    );

    // A clear accepted on the same edge wins over the write; the read still runs.
    assign rd_acc = rd_req && !busy;
    assign wr_acc = wr_req && !busy && !clr_req;

    // Array is deliberately not reset: contents survive (or half-survive) a reset.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= CLR_VAL;
        end else if (wr_acc) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
            rd_valid  <= 1'b0;
            wr_done   <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            wr_done  <= wr_acc;
            if (rd_acc) begin
                rd_data_a <= (wr_acc && wr_addr == rd_addr_a) ? wr_data : mem[rd_addr_a];
                rd_data_b <= (wr_acc && wr_addr == rd_addr_b) ? wr_data : mem[rd_addr_b];
            end
        end
    end

endmodule

// File: tb/tb_mem_bank_param.sv
// Directed self-checking bench for mem_bank_param (16x16 and 32x64 instances).
module tb_mem_bank_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // 16x16 instance
    logic        rd_req = 1'b0;
    logic [3:0]  rd_addr_a = '0, rd_addr_b = '0;
    logic [15:0] rd_data_a, rd_data_b;
    logic        rd_valid;
    logic        wr_req = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_done;
    logic        clr_req = 1'b0;
    logic        clr_done, busy;

    // 32x64 instance
    logic        w_rd_req = 1'b0;
    logic [5:0]  w_rd_addr_a = '0, w_rd_addr_b = '0;
    logic [31:0] w_rd_data_a, w_rd_data_b;
    logic        w_rd_valid;
    logic        w_wr_req = 1'b0;
    logic [5:0]  w_wr_addr = '0;
    logic [31:0] w_wr_data = '0;
    logic        w_wr_done;
    logic        w_clr_req = 1'b0;
    logic        w_clr_done, w_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_bank_param dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid(rd_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
        .clr_req(clr_req), .clr_done(clr_done), .busy(busy)
    );

    mem_bank_param #(.DATA_W(32), .ADDR_W(6)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .rd_req(w_rd_req), .rd_addr_a(w_rd_addr_a), .rd_addr_b(w_rd_addr_b),
        .rd_data_a(w_rd_data_a), .rd_data_b(w_rd_data_b), .rd_valid(w_rd_valid),
        .wr_req(w_wr_req), .wr_addr(w_wr_addr), .wr_data(w_wr_data), .wr_done(w_wr_done),
        .clr_req(w_clr_req), .clr_done(w_clr_done), .busy(w_busy)
    );

    typedef struct {
        logic        rd;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        wr;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        vld;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        wdn;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        logic busy_ok;

        // Reset state
        #2;
        chk("rst_rd_data_a", 32'(rd_data_a), 32'h0);
        chk("rst_rd_data_b", 32'(rd_data_b), 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_wr_done", 32'(wr_done), 32'h0);
        chk("rst_clr_done", 32'(clr_done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: clear sweep timing, then read every address pair
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("t1_busy", 32'(busy), 32'h1);
            chk("t1_clr_done_early", 32'(clr_done), 32'h0);
            tick();
        end
        chk("t1_clr_done", 32'(clr_done), 32'h1);
        chk("t1_busy_end", 32'(busy), 32'h0);
        tick();
        chk("t1_clr_done_pulse", 32'(clr_done), 32'h0);
        for (int i = 0; i < 16; i++) begin
            rd_req = 1'b1;
            rd_addr_a = 4'(i);
            rd_addr_b = 4'(15 - i);
            tick();
            chk("t1_rd_valid", 32'(rd_valid), 32'h1);
            chk("t1_rd_a", 32'(rd_data_a), 32'h0);
            chk("t1_rd_b", 32'(rd_data_b), 32'h0);
        end
        rd_req = 1'b0;
        tick();
        chk("t1_rd_valid_drop", 32'(rd_valid), 32'h0);

        // 2/3: table of writes, reads and same-edge forwarding
        tbl[0] = '{1'b0, 4'd0,  4'd0,  1'b1, 4'd3,  16'h1234, 1'b0, 16'h0000, 16'h0000, 1'b1};
        tbl[1] = '{1'b0, 4'd0,  4'd0,  1'b1, 4'd12, 16'hBEEF, 1'b0, 16'h0000, 16'h0000, 1'b1};
        tbl[2] = '{1'b1, 4'd3,  4'd12, 1'b0, 4'd0,  16'h0000, 1'b1, 16'h1234, 16'hBEEF, 1'b0};
        tbl[3] = '{1'b0, 4'd0,  4'd0,  1'b0, 4'd0,  16'h0000, 1'b0, 16'h1234, 16'hBEEF, 1'b0};
        tbl[4] = '{1'b0, 4'd0,  4'd0,  1'b1, 4'd5,  16'h0011, 1'b0, 16'h1234, 16'hBEEF, 1'b1};
        tbl[5] = '{1'b1, 4'd5,  4'd5,  1'b1, 4'd5,  16'h00AA, 1'b1, 16'h00AA, 16'h00AA, 1'b1};
        tbl[6] = '{1'b1, 4'd5,  4'd3,  1'b0, 4'd0,  16'h0000, 1'b1, 16'h00AA, 16'h1234, 1'b0};
        tbl[7] = '{1'b1, 4'd3,  4'd4,  1'b1, 4'd4,  16'h4444, 1'b1, 16'h1234, 16'h4444, 1'b1};
        tbl[8] = '{1'b0, 4'd0,  4'd0,  1'b0, 4'd0,  16'h0000, 1'b0, 16'h1234, 16'h4444, 1'b0};
        for (int i = 0; i < 9; i++) begin
            rd_req = tbl[i].rd;
            rd_addr_a = tbl[i].ra;
            rd_addr_b = tbl[i].rb;
            wr_req = tbl[i].wr;
            wr_addr = tbl[i].wa;
            wr_data = tbl[i].wd;
            tick();
            chk($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(tbl[i].vld));
            chk($sformatf("v%0d_rd_a", i), 32'(rd_data_a), 32'(tbl[i].ea));
            chk($sformatf("v%0d_rd_b", i), 32'(rd_data_b), 32'(tbl[i].eb));
            chk($sformatf("v%0d_wr_done", i), 32'(wr_done), 32'(tbl[i].wdn));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'h0);
        end
        rd_req = 1'b0;
        wr_req = 1'b0;

        // 4: clear+write+read on one edge; requests held during the sweep are dropped
        clr_req = 1'b1;
        wr_req = 1'b1;
        wr_addr = 4'd7;
        wr_data = 16'h7777;
        rd_req = 1'b1;
        rd_addr_a = 4'd7;
        rd_addr_b = 4'd3;
        tick();
        chk("t4_busy", 32'(busy), 32'h1);
        chk("t4_wr_done", 32'(wr_done), 32'h0);
        chk("t4_rd_valid", 32'(rd_valid), 32'h1);
        chk("t4_rd_a", 32'(rd_data_a), 32'h0);
        chk("t4_rd_b", 32'(rd_data_b), 32'h1234);
        for (int i = 1; i < 16; i++) begin
            tick();
            if (i == 8) clr_req = 1'b0;
            chk("t4_busy_sweep", 32'(busy), 32'h1);
            chk("t4_wr_done_sweep", 32'(wr_done), 32'h0);
            chk("t4_rd_valid_sweep", 32'(rd_valid), 32'h0);
            chk("t4_clr_done_sweep", 32'(clr_done), 32'h0);
        end
        tick();
        chk("t4_clr_done", 32'(clr_done), 32'h1);
        chk("t4_busy_end", 32'(busy), 32'h0);
        chk("t4_wr_done_end", 32'(wr_done), 32'h0);
        chk("t4_rd_hold_a", 32'(rd_data_a), 32'h0);
        chk("t4_rd_hold_b", 32'(rd_data_b), 32'h1234);
        wr_req = 1'b0;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("t4_rd7", 32'(rd_data_a), 32'h0);
        chk("t4_rd3", 32'(rd_data_b), 32'h0);
        chk("t4_busy_after", 32'(busy), 32'h0);

        // 5: reset in the middle of a sweep leaves a partially cleared array
        wr_req = 1'b1;
        wr_data = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            wr_addr = 4'(i);
            tick();
            chk("t5_preset_wr_done", 32'(wr_done), 32'h1);
        end
        wr_req = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("t5_busy_mid", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t5_busy_rst", 32'(busy), 32'h0);
        chk("t5_clr_done_rst", 32'(clr_done), 32'h0);
        chk("t5_rd_a_rst", 32'(rd_data_a), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_req = 1'b1;
            rd_addr_a = 4'(i);
            rd_addr_b = 4'(i + 8);
            tick();
            chk("t5_busy", 32'(busy), 32'h0);
            chk("t5_rd_lo", 32'(rd_data_a), 32'h0);
            chk("t5_rd_hi", 32'(rd_data_b), 32'hFFFF);
        end
        rd_req = 1'b0;
        tick();

        // 6: 32-bit x 64-word instance
        w_clr_req = 1'b1;
        tick();
        w_clr_req = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (!w_clr_done && cyc < 200) begin
            if (!w_busy) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        chk("t6_clr_cycles", 32'(cyc), 32'd65);
        chk("t6_busy_sweep", 32'(busy_ok), 32'h1);
        chk("t6_busy_end", 32'(w_busy), 32'h0);
        w_wr_req = 1'b1;
        w_wr_addr = 6'd63;
        w_wr_data = 32'hDEADBEEF;
        tick();
        w_wr_req = 1'b0;
        chk("t6_wr_done", 32'(w_wr_done), 32'h1);
        w_rd_req = 1'b1;
        w_rd_addr_a = 6'd63;
        w_rd_addr_b = 6'd0;
        tick();
        w_rd_req = 1'b0;
        chk("t6_rd_valid", 32'(w_rd_valid), 32'h1);
        chk("t6_rd_a", w_rd_data_a, 32'hDEADBEEF);
        chk("t6_rd_b", w_rd_data_b, 32'h0);
        tick();
        chk("t6_rd_valid_pulse", 32'(w_rd_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
